// File: rtl/controlador_pago.sv
// rtl/controlador_pago.sv - payment controller: coin accumulation, timeout/cancel refund, change output
// Optional macro CONTROLADOR_PAGO_VUELTO_EN: return overpayment as vuelto on a completed payment.
module controlador_pago #(
    parameter logic [7:0] TIMEOUT_CICLOS = 8'd200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] precio,
    input  logic        precio_valido,
    input  logic [2:0]  moneda,
    input  logic        moneda_valida,
    input  logic        cancelar,
    output logic        pago_recibido,
    output logic [15:0] monto_acumulado,
    output logic [15:0] vuelto,
    output logic        vuelto_valido,
    output logic        moneda_rechazada,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        ESPERA     = 2'b00,
        COBRO      = 2'b01,
        PAGADO     = 2'b10,
        DEVOLUCION = 2'b11
    } estado_t;

    estado_t     r_estado, w_estado_sig;
    logic [15:0] r_precio, w_precio_sig;
    logic [15:0] r_monto, w_monto_sig;
    logic [15:0] r_vuelto, w_vuelto_sig;
    logic [7:0]  r_cnt, w_cnt_sig;
    logic        r_pago, w_pago_sig;
    logic        r_vv, w_vv_sig;
    logic        r_rech, w_rech_sig;

    logic [15:0] w_valor;
    logic        w_valor_ok;
    logic [16:0] w_suma;
    logic [15:0] w_suma_sat;
    logic [8:0]  w_cnt_inc;

    always_comb begin
        w_valor    = 16'd0;
        w_valor_ok = 1'b0;
        case (moneda)
            3'b001: begin w_valor = 16'd25;   w_valor_ok = 1'b1; end
            3'b010: begin w_valor = 16'd50;   w_valor_ok = 1'b1; end
            3'b011: begin w_valor = 16'd100;  w_valor_ok = 1'b1; end
            3'b100: begin w_valor = 16'd500;  w_valor_ok = 1'b1; end
            3'b101: begin w_valor = 16'd1000; w_valor_ok = 1'b1; end
            default: begin w_valor = 16'd0;   w_valor_ok = 1'b0; end
        endcase
    end

    // Saturating at 16'hFFFF still covers any 16-bit price, so payment always completes.
    assign w_suma     = {1'b0, r_monto} + {1'b0, w_valor};
    assign w_suma_sat = w_suma[16] ? 16'hFFFF : w_suma[15:0];
    assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ESPERA;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Pulse outputs are computed on the transition so they are high during the PAGADO/DEVOLUCION cycle.
    always_comb begin
        w_estado_sig = r_estado;
        w_precio_sig = r_precio;
        w_monto_sig  = r_monto;
        w_vuelto_sig = r_vuelto;
        w_cnt_sig    = r_cnt;
        w_pago_sig   = 1'b0;
        w_vv_sig     = 1'b0;
        w_rech_sig   = moneda_valida;
        case (r_estado)
            ESPERA: begin
                if (precio_valido) begin
                    w_precio_sig = precio;
                    w_monto_sig  = 16'd0;
                    w_cnt_sig    = 8'd0;
                    if (precio == 16'd0) begin
                        w_estado_sig = PAGADO;
                        w_pago_sig   = 1'b1;
                        w_vuelto_sig = 16'd0;
`ifdef CONTROLADOR_PAGO_VUELTO_EN
                        w_vv_sig     = 1'b1;
`endif
                    end else begin
                        w_estado_sig = COBRO;
                    end
                end
            end
            COBRO: begin
                if (cancelar) begin
                    w_estado_sig = DEVOLUCION;
                    w_vv_sig     = 1'b1;
                    w_vuelto_sig = r_monto;
                end else if (moneda_valida && w_valor_ok) begin
                    w_rech_sig  = 1'b0;
                    w_monto_sig = w_suma_sat;
                    w_cnt_sig   = 8'd0;
                    if (w_suma_sat >= r_precio) begin
                        w_estado_sig = PAGADO;
                        w_pago_sig   = 1'b1;
`ifdef CONTROLADOR_PAGO_VUELTO_EN
                        w_vuelto_sig = w_suma_sat - r_precio;
                        w_vv_sig     = 1'b1;
`else
                        w_vuelto_sig = 16'd0;
`endif
                    end
                end else begin
                    w_cnt_sig = w_cnt_inc[7:0];
                    if (w_cnt_inc >= {1'b0, TIMEOUT_CICLOS}) begin
                        w_estado_sig = DEVOLUCION;
                        w_vv_sig     = 1'b1;
                        w_vuelto_sig = r_monto;
                    end
                end
            end
            PAGADO, DEVOLUCION: begin
                w_estado_sig = ESPERA;
                w_monto_sig  = 16'd0;
                w_cnt_sig    = 8'd0;
            end
            default: w_estado_sig = ESPERA;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_precio <= 16'd0;
            r_monto  <= 16'd0;
            r_vuelto <= 16'd0;
            r_cnt    <= 8'd0;
            r_pago   <= 1'b0;
            r_vv     <= 1'b0;
            r_rech   <= 1'b0;
        end else begin
            r_precio <= w_precio_sig;
            r_monto  <= w_monto_sig;
            r_vuelto <= w_vuelto_sig;
            r_cnt    <= w_cnt_sig;
            r_pago   <= w_pago_sig;
            r_vv     <= w_vv_sig;
            r_rech   <= w_rech_sig;
        end
    end

    assign pago_recibido    = r_pago;
    assign monto_acumulado  = r_monto;
    assign vuelto           = r_vuelto;
    assign vuelto_valido    = r_vv;
    assign moneda_rechazada = r_rech;
    assign estado           = r_estado;

endmodule

// File: tb/tb_controlador_pago.sv
// tb/tb_controlador_pago.sv - scoreboard bench for controlador_pago
module tb_controlador_pago;

    localparam logic [7:0] TO = 8'd16;
`ifdef CONTROLADOR_PAGO_VUELTO_EN
    localparam logic VE = 1'b1;
`else
    localparam logic VE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] precio;
    logic        precio_valido;
    logic [2:0]  moneda;
    logic        moneda_valida;
    logic        cancelar;
    logic        pago_recibido;
    logic [15:0] monto_acumulado;
    logic [15:0] vuelto;
    logic        vuelto_valido;
    logic        moneda_rechazada;
    logic [1:0]  estado;

    always #5 clock = ~clock;

    controlador_pago #(.TIMEOUT_CICLOS(TO)) dut (
        .clock(clock), .reset(reset),
        .precio(precio), .precio_valido(precio_valido),
        .moneda(moneda), .moneda_valida(moneda_valida),
        .cancelar(cancelar),
        .pago_recibido(pago_recibido), .monto_acumulado(monto_acumulado),
        .vuelto(vuelto), .vuelto_valido(vuelto_valido),
        .moneda_rechazada(moneda_rechazada), .estado(estado)
    );

    typedef struct {
        logic        pago;
        logic        vv;
        logic [15:0] vuelto;
        logic        rech;
    } evento_t;

    evento_t q[$];
    int n_comp = 0;
    int n_err  = 0;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observado=%0d esperado=%0d", tag, obs, esp);
        end
    endtask

    task automatic esperar(input logic pago, input logic vv, input logic [15:0] vu, input logic rech);
        evento_t e;
        e.pago = pago; e.vv = vv; e.vuelto = vu; e.rech = rech;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (pago_recibido || vuelto_valido || moneda_rechazada) begin
            if (q.size() == 0) begin
                comprobar("evento_inesperado", {29'd0, pago_recibido, vuelto_valido, moneda_rechazada}, 32'd0);
            end else begin
                evento_t e;
                e = q.pop_front();
                comprobar("ev_pago", pago_recibido, e.pago);
                comprobar("ev_vuelto_valido", vuelto_valido, e.vv);
                comprobar("ev_rechazo", moneda_rechazada, e.rech);
                if (e.pago || e.vv) comprobar("ev_vuelto", vuelto, e.vuelto);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fijar_precio(input logic [15:0] p);
        precio = p; precio_valido = 1'b1;
        tick();
        precio_valido = 1'b0;
    endtask

    task automatic meter(input logic [2:0] code);
        moneda = code; moneda_valida = 1'b1;
        tick();
        moneda_valida = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulacion sin terminar");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; precio = 16'd0; precio_valido = 1'b0;
        moneda = 3'd0; moneda_valida = 1'b0; cancelar = 1'b0;
        #12;
        comprobar("rst_estado", estado, 0);
        comprobar("rst_monto", monto_acumulado, 0);
        comprobar("rst_vuelto", vuelto, 0);
        comprobar("rst_pulsos", {pago_recibido, vuelto_valido, moneda_rechazada}, 0);
        @(negedge clock); reset = 1'b1;
        tick();

        // precio 500, coins 100,100,500
        fijar_precio(16'd500);
        comprobar("t1_cobro", estado, 1);
        meter(3'b011);
        comprobar("t1_monto100", monto_acumulado, 100);
        meter(3'b011);
        comprobar("t1_monto200", monto_acumulado, 200);
        esperar(1'b1, VE, VE ? 16'd200 : 16'd0, 1'b0);
        meter(3'b100);
        comprobar("t1_pagado", estado, 2);
        tick();
        comprobar("t1_espera", estado, 0);
        comprobar("t1_monto0", monto_acumulado, 0);

        // precio 1000, coin 500, cancel
        fijar_precio(16'd1000);
        meter(3'b100);
        comprobar("t2_monto", monto_acumulado, 500);
        esperar(1'b0, 1'b1, 16'd500, 1'b0);
        cancelar = 1'b1; tick(); cancelar = 1'b0;
        comprobar("t2_devolucion", estado, 3);
        tick();
        comprobar("t2_espera", estado, 0);
        comprobar("t2_monto0", monto_acumulado, 0);

        // timeout refund
        fijar_precio(16'd750);
        meter(3'b001);
        esperar(1'b0, 1'b1, 16'd25, 1'b0);
        n = 0;
        while (estado != 2'd3 && n < 40) begin
            tick();
            n++;
        end
        comprobar("t3_ciclos_timeout", n, TO);
        tick();
        comprobar("t3_espera", estado, 0);
        comprobar("t3_monto0", monto_acumulado, 0);

        // invalid coin in COBRO, coin in ESPERA
        fijar_precio(16'd300);
        meter(3'b001);
        esperar(1'b0, 1'b0, 16'd0, 1'b1);
        meter(3'b111);
        comprobar("t4_monto_sin_cambio", monto_acumulado, 25);
        comprobar("t4_cobro", estado, 1);
        esperar(1'b0, 1'b1, 16'd25, 1'b0);
        cancelar = 1'b1; tick(); cancelar = 1'b0;
        tick();
        esperar(1'b0, 1'b0, 16'd0, 1'b1);
        meter(3'b010);
        comprobar("t4_monto_espera", monto_acumulado, 0);
        comprobar("t4_espera", estado, 0);

        // coin strobed together with cancel is rejected
        fijar_precio(16'd200);
        meter(3'b010);
        esperar(1'b0, 1'b1, 16'd50, 1'b1);
        moneda = 3'b011; moneda_valida = 1'b1; cancelar = 1'b1;
        tick();
        moneda_valida = 1'b0; cancelar = 1'b0;
        comprobar("t5_devolucion", estado, 3);
        comprobar("t5_monto", monto_acumulado, 50);
        tick();

        // precio_valido in COBRO ignored
        fijar_precio(16'd100);
        precio = 16'd25; precio_valido = 1'b1; tick(); precio_valido = 1'b0;
        meter(3'b010);
        comprobar("t6_precio_retenido", estado, 1);
        esperar(1'b1, VE, 16'd0, 1'b0);
        meter(3'b010);
        comprobar("t6_pagado", estado, 2);
        tick();

        // cancel outside COBRO ignored
        cancelar = 1'b1; tick(); cancelar = 1'b0;
        comprobar("t7_cancel_espera", estado, 0);

        // saturation at 16'hFFFF
        fijar_precio(16'hFFFF);
        repeat (65) meter(3'b101);
        comprobar("t8_monto65000", monto_acumulado, 65000);
        comprobar("t8_cobro", estado, 1);
        esperar(1'b1, VE, 16'd0, 1'b0);
        meter(3'b101);
        comprobar("t8_pagado", estado, 2);
        comprobar("t8_saturado", monto_acumulado, 16'hFFFF);
        tick();

        // reset mid-COBRO, then zero price
        fijar_precio(16'd1750);
        meter(3'b101);
        comprobar("t9_monto", monto_acumulado, 1000);
        @(negedge clock);
        reset = 1'b0;
        #1;
        comprobar("t9_rst_estado", estado, 0);
        comprobar("t9_rst_monto", monto_acumulado, 0);
        comprobar("t9_rst_vuelto", vuelto, 0);
        comprobar("t9_rst_pulsos", {pago_recibido, vuelto_valido, moneda_rechazada}, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        esperar(1'b1, VE, 16'd0, 1'b0);
        fijar_precio(16'd0);
        comprobar("t9_pagado", estado, 2);
        tick();
        comprobar("t9_espera", estado, 0);

        repeat (2) tick();
        comprobar("pendientes", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
        $finish;
    end

endmodule
